// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button synchronise/debounce, start/stop FSM, tick prescaler.
// Optional auto-stop on counter carry is enabled by defining STOPWATCH_AUTO_STOP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 100,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_dir,
  input  logic       btn_load,
  input  logic [3:0] preset,
`ifdef STOPWATCH_AUTO_STOP_EN
  input  logic       cnt_carry,
`endif
  output logic       cnt_enable,
  output logic       cnt_up,
  output logic       cnt_load,
  output logic [3:0] load_value,
  output logic       cnt_clear,
  output logic       running
);

  localparam int DBW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int PW  = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Button bit order: 0 start, 1 clear, 2 dir, 3 load
  logic [3:0]          btn_raw_s;
  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          level_q, level_d;
  logic [3:0]          press_q, press_d;
  logic [3:0][DBW-1:0] db_cnt_q, db_cnt_d;

  assign btn_raw_s = {btn_load, btn_dir, btn_clear, btn_start};

  // Debounce: the level flips once the synchronised value has disagreed for DEBOUNCE_CYCLES edges
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
    press_d = level_d & ~level_q;
  end

  // Synchroniser, debounce and press-event registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      level_q  <= 4'b0000;
      press_q  <= 4'b0000;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw_s;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  logic ev_clear_s, ev_load_s, ev_start_s, ev_dir_s, carry_s;

  assign ev_clear_s = press_q[1];
  assign ev_load_s  = press_q[3] & ~press_q[1];
  assign ev_start_s = press_q[0] & ~press_q[1] & ~press_q[3];
  assign ev_dir_s   = press_q[2] & ~press_q[0] & ~press_q[1] & ~press_q[3];

`ifdef STOPWATCH_AUTO_STOP_EN
  assign carry_s = cnt_carry;
`else
  assign carry_s = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            cnt_up_q, cnt_up_d;
  logic [3:0]      load_value_q, load_value_d;
  logic            cnt_load_q, cnt_load_d;
  logic            cnt_clear_q, cnt_clear_d;
  logic            cnt_enable_q, cnt_enable_d;
  logic            running_q, running_d;

  // Next state, prescaler and strobes; in RUN only start (or carry) acts
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_up_d     = cnt_up_q;
    load_value_d = load_value_q;
    cnt_load_d   = 1'b0;
    cnt_clear_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (ev_start_s || carry_s) begin
          state_d = PAUSE;
        end else if (presc_q == PW'(TICK_DIV - 1)) begin
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      IDLE, PAUSE: begin
        if (ev_clear_s) begin
          state_d     = IDLE;
          presc_d     = '0;
          cnt_clear_d = 1'b1;
        end else if (ev_load_s) begin
          load_value_d = preset;
          cnt_load_d   = 1'b1;
        end else if (ev_start_s) begin
          state_d = RUN;
          if (state_q == IDLE) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q;
          end
        end else if (ev_dir_s) begin
          cnt_up_d = ~cnt_up_q;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
    // Strobe is aligned with the cycle the registered prescaler sits at TICK_DIV-1 in RUN
    cnt_enable_d = (state_d == RUN) && (presc_d == PW'(TICK_DIV - 1));
    running_d    = (state_d == RUN);
  end

  // FSM state, prescaler and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      cnt_up_q     <= 1'b1;
      load_value_q <= 4'd0;
      cnt_load_q   <= 1'b0;
      cnt_clear_q  <= 1'b0;
      cnt_enable_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_up_q     <= cnt_up_d;
      load_value_q <= load_value_d;
      cnt_load_q   <= cnt_load_d;
      cnt_clear_q  <= cnt_clear_d;
      cnt_enable_q <= cnt_enable_d;
      running_q    <= running_d;
    end
  end

  assign cnt_enable = cnt_enable_q;
  assign cnt_up     = cnt_up_q;
  assign cnt_load   = cnt_load_q;
  assign load_value = load_value_q;
  assign cnt_clear  = cnt_clear_q;
  assign running    = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised self-checking bench for stopwatch_ctrl against a behavioural reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, btn_clear, btn_dir, btn_load;
  logic [3:0] preset;
  logic       carry;
  logic       cnt_enable, cnt_up, cnt_load, cnt_clear, running;
  logic [3:0] load_value;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_dir    (btn_dir),
    .btn_load   (btn_load),
    .preset     (preset),
`ifdef STOPWATCH_AUTO_STOP_EN
    .cnt_carry  (carry),
`endif
    .cnt_enable (cnt_enable),
    .cnt_up     (cnt_up),
    .cnt_load   (cnt_load),
    .load_value (load_value),
    .cnt_clear  (cnt_clear),
    .running    (running)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_strobes = 0;

  // Reference model: mode 0 IDLE, 1 RUN, 2 PAUSE
  int       m_mode, m_presc;
  bit       m_up, m_load, m_clear;
  bit [3:0] m_lv;
  bit [3:0] m_s1, m_s2, m_lvl, m_press;
  bit       m_hist [4][DB];   // most recent DB synchronised samples per button

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_presc = 0; m_up = 1'b1; m_lv = 4'd0; m_load = 1'b0; m_clear = 1'b0;
    m_s1 = 4'd0; m_s2 = 4'd0; m_lvl = 4'd0; m_press = 4'd0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < DB; k++) m_hist[b][k] = 1'b0;
  endtask

  // One clock edge of the model, using input values present before the edge
  task automatic model_step();
    bit [3:0] raw, new_press;
    bit       all_diff;
    raw = {btn_load, btn_dir, btn_clear, btn_start};
    m_load = 1'b0; m_clear = 1'b0;
    if (m_mode == 1) begin
      if (m_press[0] && !m_press[1] && !m_press[3]) m_mode = 2;
      else m_presc = (m_presc + 1) % TD;
    end else if (m_press[1]) begin
      m_mode = 0; m_presc = 0; m_clear = 1'b1;
    end else if (m_press[3]) begin
      m_lv = preset; m_load = 1'b1;
    end else if (m_press[0]) begin
      if (m_mode == 0) m_presc = 0;
      m_mode = 1;
    end else if (m_press[2]) begin
      m_up = ~m_up;
    end
    new_press = 4'd0;
    for (int b = 0; b < 4; b++) begin
      for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
      m_hist[b][0] = m_s2[b];
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl[b] = ~m_lvl[b];
        new_press[b] = m_lvl[b];
      end
    end
    m_press = new_press;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check_all();
    bit exp_en;
    exp_en = (m_mode == 1) && (m_presc == TD - 1);
    if (cnt_enable === 1'b1) n_strobes++;
    chk("cnt_enable", {7'd0, cnt_enable}, {7'd0, exp_en});
    chk("running",    {7'd0, running},    {7'd0, m_mode == 1});
    chk("cnt_up",     {7'd0, cnt_up},     {7'd0, m_up});
    chk("cnt_load",   {7'd0, cnt_load},   {7'd0, m_load});
    chk("cnt_clear",  {7'd0, cnt_clear},  {7'd0, m_clear});
    chk("load_value", {4'd0, load_value}, {4'd0, m_lv});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  int dur [4];
  bit [3:0] lvl;

  initial begin
    reset = 1'b0; carry = 1'b0;
    btn_start = 1'b0; btn_clear = 1'b0; btn_dir = 1'b0; btn_load = 1'b0;
    preset = 4'd0;
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Directed: 2-cycle glitch on start is filtered, then a held press starts the run
    btn_start = 1'b1; tick(); tick(); btn_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    btn_start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_start = 1'b0;
    for (int i = 0; i < 12; i++) tick();

    // Randomised button activity with occasional mid-operation reset
    lvl = 4'd0;
    for (int b = 0; b < 4; b++) dur[b] = $urandom_range(1, 20);
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        dur[b]--;
        if (dur[b] <= 0) begin
          lvl[b] = ~lvl[b];
          dur[b] = (b == 0) ? $urandom_range(1, 24) : $urandom_range(1, 15);
        end
      end
      {btn_load, btn_dir, btn_clear, btn_start} = lvl;
      preset = 4'($urandom_range(0, 15));
      if (c % 997 == 996) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b1;
      end
      tick();
    end

    chk("strobes_seen", {7'd0, n_strobes > 0}, 8'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
